// File: rtl/systolic_phase_sequencer_if.sv
// Control bundle between the top-level controller (master) and the
// systolic phase sequencer (slave).
interface systolic_phase_sequencer_if #(
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 4,
  parameter int TILE_WIDTH  = 4
);
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                   start;
  logic [TILE_WIDTH-1:0]  num_tiles;
  logic                   enable;
  logic                   abort;
  logic                   busy;
  logic [1:0]             phase;
  logic                   load_en;
  logic                   compute_en;
  logic                   drain_en;
  logic [ROW_W-1:0]       row_sel;
  logic [COUNT_WIDTH-1:0] counter_out;
  logic                   phase_last;
  logic [TILE_WIDTH-1:0]  tile_idx;
  logic                   tile_done;
  logic                   done;

  modport master (
    output start, num_tiles, enable, abort,
    input  busy, phase, load_en, compute_en, drain_en, row_sel,
           counter_out, phase_last, tile_idx, tile_done, done
  );

  modport slave (
    input  start, num_tiles, enable, abort,
    output busy, phase, load_en, compute_en, drain_en, row_sel,
           counter_out, phase_last, tile_idx, tile_done, done
  );
endinterface

// File: rtl/systolic_phase_sequencer.sv
// Multi-tile LOAD/COMPUTE/DRAIN phase sequencer for the systolic array,
// with stall (enable), synchronous abort and a runtime tile count.
module systolic_phase_sequencer #(
  parameter int DEPTH       = 4,
  parameter int COMPUTE_LEN = 2*DEPTH-1,
  parameter int COUNT_WIDTH = 4,
  parameter int TILE_WIDTH  = 4
) (
  input logic clk,
  input logic rst_counter,
  systolic_phase_sequencer_if.slave bus
);
  localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [COUNT_WIDTH-1:0] EDGE_LAST = COUNT_WIDTH'(DEPTH-1);
  localparam logic [COUNT_WIDTH-1:0] COMP_LAST = COUNT_WIDTH'(COMPUTE_LEN-1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [TILE_WIDTH-1:0]  TILE_ONE  = TILE_WIDTH'(1);

  logic [2:0]             state_p0, state_nxt;
  logic [COUNT_WIDTH-1:0] cnt_p0, cnt_nxt;
  logic [TILE_WIDTH-1:0]  tile_p0, tile_nxt;
  logic [TILE_WIDTH-1:0]  ntiles_p0, ntiles_nxt;
  logic                   in_phase;
  logic                   at_last;
  logic [COUNT_WIDTH-1:0] last_cnt;

  always_comb begin
    in_phase = (state_p0 == S_LOAD) || (state_p0 == S_COMPUTE) || (state_p0 == S_DRAIN);
    last_cnt = (state_p0 == S_COMPUTE) ? COMP_LAST : EDGE_LAST;
    at_last  = in_phase && (cnt_p0 == last_cnt);
  end

  // Next-state: abort outranks everything outside IDLE; enable gates only phase progress
  always_comb begin
    state_nxt  = state_p0;
    cnt_nxt    = cnt_p0;
    tile_nxt   = tile_p0;
    ntiles_nxt = ntiles_p0;
    if (bus.abort && (state_p0 != S_IDLE)) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
      tile_nxt  = '0;
    end else begin
      case (state_p0)
        S_IDLE: begin
          if (bus.start && !bus.abort && (bus.num_tiles != '0)) begin
            state_nxt  = S_LOAD;
            cnt_nxt    = '0;
            tile_nxt   = '0;
            ntiles_nxt = bus.num_tiles;
          end
        end
        S_DONE: begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
          tile_nxt  = '0;
        end
        default: begin
          if (bus.enable) begin
            if (at_last) begin
              cnt_nxt = '0;
              case (state_p0)
                S_LOAD:    state_nxt = S_COMPUTE;
                S_COMPUTE: state_nxt = S_DRAIN;
                default: begin
                  if (tile_p0 < (ntiles_p0 - TILE_ONE)) begin
                    tile_nxt  = tile_p0 + TILE_ONE;
                    state_nxt = S_LOAD;
                  end else begin
                    state_nxt = S_DONE;
                  end
                end
              endcase
            end else begin
              cnt_nxt = cnt_p0 + CNT_ONE;
            end
          end
        end
      endcase
    end
  end

  // Stage p0: sequencer state registers
  always_ff @(posedge clk or posedge rst_counter) begin
    if (rst_counter) begin
      state_p0  <= S_IDLE;
      cnt_p0    <= '0;
      tile_p0   <= '0;
      ntiles_p0 <= '0;
    end else begin
      state_p0  <= state_nxt;
      cnt_p0    <= cnt_nxt;
      tile_p0   <= tile_nxt;
      ntiles_p0 <= ntiles_nxt;
    end
  end

  // DONE reports phase 0; the other encodings map straight onto the phase code
  assign bus.busy        = (state_p0 != S_IDLE);
  assign bus.phase       = (state_p0 == S_DONE) ? 2'd0 : state_p0[1:0];
  assign bus.load_en     = (state_p0 == S_LOAD)    && bus.enable;
  assign bus.compute_en  = (state_p0 == S_COMPUTE) && bus.enable;
  assign bus.drain_en    = (state_p0 == S_DRAIN)   && bus.enable;
  assign bus.row_sel     = ((state_p0 == S_LOAD) || (state_p0 == S_DRAIN)) ? cnt_p0[ROW_W-1:0] : '0;
  assign bus.counter_out = cnt_p0;
  assign bus.phase_last  = bus.enable && at_last;
  assign bus.tile_idx    = tile_p0;
  assign bus.tile_done   = (state_p0 == S_DRAIN) && bus.enable && !bus.abort && (cnt_p0 == EDGE_LAST);
  assign bus.done        = (state_p0 == S_DONE);
endmodule

// File: tb/tb_systolic_phase_sequencer.sv
// Bench for systolic_phase_sequencer: vector table, directed multi-cycle
// sequences and randomized traffic against a position-based reference model.
module tb_systolic_phase_sequencer;
  localparam int D = 4;
  localparam int C = 2*D-1;
  localparam int T = 2*D + C;

  logic clk;
  logic rst_counter;

  systolic_phase_sequencer_if #(.DEPTH(D), .COUNT_WIDTH(4), .TILE_WIDTH(4)) bus ();

  systolic_phase_sequencer #(.DEPTH(D), .COMPUTE_LEN(C), .COUNT_WIDTH(4), .TILE_WIDTH(4)) dut (
    .clk         (clk),
    .rst_counter (rst_counter),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an op is a linear count of advancing cycles m_t in [0, m_n*T)
  bit m_active = 0;
  bit m_done   = 0;
  int m_t      = 0;
  int m_n      = 0;

  logic [18:0] obs;

  int r_bc, r_tdc, r_first, r_last, r_dc;
  bit r_ok;

  typedef struct {
    logic       st;
    logic [3:0] nt;
    logic       en;
    logic       ab;
    logic       busy;
    logic [1:0] ph;
    logic [3:0] cnt;
    logic [3:0] ti;
    logic       strb;
    logic       last;
    logic       td;
    logic       dn;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [18:0] dut_out();
    return {bus.busy, bus.phase, bus.load_en, bus.compute_en, bus.drain_en, bus.row_sel,
            bus.counter_out, bus.phase_last, bus.tile_idx, bus.tile_done, bus.done};
  endfunction

  function automatic logic [18:0] model_out(input logic en, input logic ab);
    logic busy, le, ce, de, pl, td, dn;
    logic [1:0] ph, rs;
    logic [3:0] cnt, ti;
    int r, len;
    busy = 0; le = 0; ce = 0; de = 0; pl = 0; td = 0; dn = 0;
    ph = 0; rs = 0; cnt = 0; ti = 0; len = 0;
    if (m_done) begin
      busy = 1; dn = 1; ti = 4'(m_n - 1);
    end else if (m_active) begin
      busy = 1;
      ti = 4'(m_t / T);
      r  = m_t % T;
      if (r < D) begin ph = 2'd1; cnt = 4'(r); len = D; end
      else if (r < D + C) begin ph = 2'd2; cnt = 4'(r - D); len = C; end
      else begin ph = 2'd3; cnt = 4'(r - D - C); len = D; end
      le = en && (ph == 2'd1);
      ce = en && (ph == 2'd2);
      de = en && (ph == 2'd3);
      pl = en && (int'(cnt) == len - 1);
      td = en && !ab && (ph == 2'd3) && (int'(cnt) == D - 1);
      rs = (ph != 2'd2) ? cnt[1:0] : 2'd0;
    end
    return {busy, ph, le, ce, de, rs, cnt, pl, ti, td, dn};
  endfunction

  task automatic model_clock(input logic st, input logic [3:0] nt, input logic en, input logic ab);
    if ((m_active || m_done) && ab) begin
      m_active = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_active) begin
      if (en) begin
        m_t++;
        if (m_t == m_n * T) begin m_active = 0; m_done = 1; end
      end
    end else if (st && !ab && nt != 0) begin
      m_active = 1; m_t = 0; m_n = int'(nt);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive after posedge, compare at negedge, advance model at posedge
  task automatic step(input logic st, input logic [3:0] nt, input logic en, input logic ab);
    logic [18:0] exp_o;
    bus.start = st; bus.num_tiles = nt; bus.enable = en; bus.abort = ab;
    @(negedge clk);
    obs   = dut_out();
    exp_o = model_out(en, ab);
    check("cycle_model", 32'(obs), 32'(exp_o));
    @(posedge clk);
    model_clock(st, nt, en, ab);
    #1;
  endtask

  task automatic run_op(input int nt, input bit issue_start, input int stall_r, input int stall_len,
                        input bit start_in_compute, input int chain_nt);
    int stall_left;
    bit prev_done;
    logic st, en;
    logic [3:0] ntv;
    stall_left = stall_len;
    prev_done = 0;
    r_bc = 0; r_tdc = 0; r_first = 0; r_last = 0; r_dc = 0; r_ok = 0;
    if (issue_start) step(1'b1, 4'(nt), 1'b1, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      st = 0; ntv = 0; en = 1;
      if (m_active && stall_left > 0 && (m_t % T) == stall_r) begin en = 0; stall_left--; end
      if (start_in_compute && m_active && (m_t % T) == D + 1) begin st = 1; ntv = 4'd7; end
      if (prev_done && chain_nt != 0) begin st = 1; ntv = 4'(chain_nt); end
      step(st, ntv, en, 1'b0);
      if (!en) begin
        check("stall_counter_hold", 32'(obs[10:7]), 32'd2);
        check("stall_compute_en", 32'(obs[14]), 32'd0);
      end
      prev_done = 0;
      if (obs[18]) begin
        r_bc++;
        if (obs[1]) begin
          r_tdc++;
          if (r_first == 0) r_first = r_bc;
          r_last = r_bc;
        end
        if (obs[0]) begin r_dc++; prev_done = 1; end
      end else if (r_bc > 0) begin
        r_ok = 1;
        break;
      end
    end
    if (!r_ok) check("op_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] tact, texp;

  initial begin
    rst_counter = 1'b1;
    bus.start = 0; bus.num_tiles = 0; bus.enable = 0; bus.abort = 0;
    #1;
    check("reset_outputs", 32'(dut_out()), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_counter = 1'b0;
    @(posedge clk);
    #1;

    //             st    nt    en    ab    busy  ph    cnt   ti    strb  last  td    dn
    vecs[0]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 2'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd5, 1'b1, 1'b0, 1'b1, 2'd1, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 2'd1, 4'd2, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 2'd1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].st, vecs[i].nt, vecs[i].en, vecs[i].ab);
      tact = 32'({obs[18], obs[17:16], obs[10:7], obs[5:2], |obs[15:13], obs[6], obs[1], obs[0]});
      texp = 32'({vecs[i].busy, vecs[i].ph, vecs[i].cnt, vecs[i].ti, vecs[i].strb,
                  vecs[i].last, vecs[i].td, vecs[i].dn});
      check($sformatf("table_vec_%0d", i), tact, texp);
    end

    // Basic single-tile op
    run_op(1, 1, -1, 0, 0, 0);
    check("basic_busy_cycles", 32'(r_bc), 32'd16);
    check("basic_tile_done_at", 32'(r_first), 32'd15);
    check("basic_done_count", 32'(r_dc), 32'd1);

    // Three tiles
    run_op(3, 1, -1, 0, 0, 0);
    check("multi_busy_cycles", 32'(r_bc), 32'd46);
    check("multi_tile_done_count", 32'(r_tdc), 32'd3);
    check("multi_first_tile_done", 32'(r_first), 32'd15);
    check("multi_last_tile_done", 32'(r_last), 32'd45);
    check("multi_done_count", 32'(r_dc), 32'd1);

    // Three-cycle stall at COMPUTE counter 2
    run_op(1, 1, D + 2, 3, 0, 0);
    check("stall_busy_cycles", 32'(r_bc), 32'd19);

    // Start during COMPUTE is ignored
    run_op(1, 1, -1, 0, 1, 0);
    check("start_in_compute_busy", 32'(r_bc), 32'd16);

    // Back-to-back: start on the IDLE cycle right after done
    run_op(1, 1, -1, 0, 0, 2);
    check("b2b_first_busy", 32'(r_bc), 32'd16);
    run_op(2, 0, -1, 0, 0, 0);
    check("b2b_second_busy", 32'(r_bc), 32'd31);
    check("b2b_second_tiles", 32'(r_tdc), 32'd2);

    // Abort at DRAIN counter 1 of tile 1 with enable high
    begin
      int dc;
      dc = 0;
      step(1'b1, 4'd2, 1'b1, 1'b0);
      for (int k = 0; k < 100 && !(m_active && m_t == T + D + C + 1); k++) begin
        step(1'b0, 4'd0, 1'b1, 1'b0);
        if (obs[0]) dc++;
      end
      check("abort_reached_point", 32'(m_t), 32'(T + D + C + 1));
      step(1'b0, 4'd0, 1'b1, 1'b1);
      check("abort_cycle_strobes", 32'({obs[1], obs[0]}), 32'd0);
      step(1'b0, 4'd0, 1'b1, 1'b0);
      check("abort_after_state", 32'({obs[18], obs[10:7], obs[5:2]}), 32'd0);
      check("abort_no_done", 32'(dc), 32'd0);
      run_op(1, 1, -1, 0, 0, 0);
      check("post_abort_busy", 32'(r_bc), 32'd16);
    end

    // Maximum tile count runs without tile_idx wrap
    run_op(15, 1, -1, 0, 0, 0);
    check("max_tiles_busy", 32'(r_bc), 32'd226);
    check("max_tiles_tile_done", 32'(r_tdc), 32'd15);

    // Asynchronous reset mid-COMPUTE, between clock edges
    step(1'b1, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 40 && !(m_active && (m_t % T) == D + 3); k++) step(1'b0, 4'd0, 1'b1, 1'b0);
    check("pre_reset_in_compute", 32'(dut_out() >> 16), 32'b110);
    #2 rst_counter = 1'b1;
    #1;
    check("async_reset_outputs", 32'(dut_out()), 32'd0);
    m_active = 0; m_done = 0; m_t = 0; m_n = 0;
    @(negedge clk) rst_counter = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) step(1'b0, 4'd0, 1'b1, 1'b0);
    check("post_reset_idle", 32'(obs[18]), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic st, en, ab;
      logic [3:0] nt;
      st = ($urandom_range(0, 5) == 0);
      nt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      en = ($urandom_range(0, 4) != 0);
      ab = ($urandom_range(0, 59) == 0);
      step(st, nt, en, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/systolic_phase_sequencer.md
Name: systolic_phase_sequencer

Overview:
Parameterised multi-tile phase sequencer for the systolic array. It generates the weight load, compute and drain phases for each tile of a multi-tile operation from a single start pulse. It also generates the row-select, last-cycle and tile/op-complete strobes, and supports stall, abort and a runtime tile count. It sits between the top-level controller and the array, input skew buffers and PISO output path.

Parameters:
DEPTH, 4, array dimension (rows = cols); LOAD and DRAIN phases last DEPTH cycles each
COMPUTE_LEN, 2*DEPTH-1, COMPUTE phase length in cycles (covers operand skew)
COUNT_WIDTH, 4, width of counter_out; must hold max(DEPTH, COMPUTE_LEN)-1
TILE_WIDTH, 4, width of num_tiles and tile_idx

Ports:
clk  in  1  clock; all state updates on rising edge
rst_counter  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin an operation; sampled only in IDLE
num_tiles  in  TILE_WIDTH  tiles in the operation; latched on accepted start
enable  in  1  advance when 1; stall (hold all state) when 0
abort  in  1  synchronous abort; returns to IDLE
busy  out  1  high in every state except IDLE
phase  out  2  0=IDLE, 1=LOAD, 2=COMPUTE, 3=DRAIN (DONE reports 0)
load_en  out  1  phase==LOAD && enable
compute_en  out  1  phase==COMPUTE && enable
drain_en  out  1  phase==DRAIN && enable
row_sel  out  $clog2(DEPTH)  counter_out[$clog2(DEPTH)-1:0] in LOAD/DRAIN, else 0
counter_out  out  COUNT_WIDTH  cycle index within current phase
phase_last  out  1  enable && counter_out == current phase length-1 (LOAD/COMPUTE/DRAIN only)
tile_idx  out  TILE_WIDTH  index of tile in progress, 0-based
tile_done  out  1  one-cycle pulse on the last advancing DRAIN cycle of each tile
done  out  1  one-cycle pulse while in DONE state

Behaviour:
- States are IDLE, LOAD, COMPUTE, DRAIN, DONE.
- Reset (asynchronous, any time): state=IDLE, counter=0, tile_idx=0, latched tile count=0. All outputs are therefore 0.
- IDLE: if start && num_tiles!=0, latch num_tiles and go to LOAD with counter=0 and tile_idx=0. start with num_tiles==0 is ignored: busy stays 0 and done is never pulsed. enable is not required to accept start.
- start outside IDLE is ignored; num_tiles changes after the latch have no effect.
- In LOAD, COMPUTE and DRAIN, each cycle with enable=1 increments the counter:
  - LOAD at DEPTH-1: counter to 0, go to COMPUTE.
  - COMPUTE at COMPUTE_LEN-1: counter to 0, go to DRAIN.
  - DRAIN at DEPTH-1: counter to 0 and tile_done=1 that cycle. If tile_idx < latched-1, tile_idx+1 and go to LOAD; else go to DONE.
- enable=0: state, counter and tile_idx hold. load_en, compute_en, drain_en, phase_last and tile_done are 0. phase, row_sel, counter_out and tile_idx stay visible.
- DONE: done=1 and busy=1 for exactly one cycle regardless of enable. Next state is IDLE with tile_idx cleared.
- abort=1 in any non-IDLE state: next state IDLE, counter=0, tile_idx=0.
  - abort has priority over enable and over a phase transition in the same cycle.
  - done is not pulsed.
  - tile_done is suppressed in the abort cycle.
  - abort in IDLE has no effect, and abort wins over a simultaneous start.
- Latency: from the start edge to first load_en is 1 cycle. A stall-free tile takes 2*DEPTH+COMPUTE_LEN cycles. A stall-free op of N tiles has busy high for N*(2*DEPTH+COMPUTE_LEN)+1 cycles.
- A new start is accepted on the first IDLE cycle after DONE (back-to-back ops allowed).
- All comparisons are unsigned at COUNT_WIDTH/TILE_WIDTH. num_tiles = 2^TILE_WIDTH-1 must run the full count without tile_idx wrap.

Test Plan:
1. Basic op (DEPTH=4, num_tiles=1, enable=1, start 1 cycle):
   - phases are LOAD 4, COMPUTE 7, DRAIN 4 cycles, with row_sel 0,1,2,3 in LOAD and DRAIN.
   - tile_done on the 15th busy cycle, done on the 16th; busy high 16 cycles, then IDLE.
2. Multi-tile (num_tiles=3): tile_idx steps 0→1→2; tile_done pulses 3 times, 15 cycles apart; a single done after cycle 45; busy high 46 cycles.
3. Stall (enable=0 for 3 cycles at COMPUTE counter=2): counter_out holds at 2 and compute_en=0 during the stall; the op completes exactly 3 cycles later than case 1.
4. Abort at DRAIN counter=1 of tile 1 (num_tiles=2), with enable=1 in the same cycle:
   - next cycle IDLE, counter_out=0, tile_idx=0.
   - no tile_done or done.
   - a subsequent start runs normally.
5. Edge starts:
   - start with num_tiles=0 → busy stays 0, no done.
   - start during COMPUTE → ignored, current op unaffected.
   - start on the IDLE cycle right after done → accepted, back-to-back op runs.
6. Asynchronous reset asserted mid-COMPUTE, between clock edges: all outputs 0 immediately. After release, the block stays IDLE until a new start.
